sha2_multiblock_engine: RTL and testbench
=========================================

Name: sha2_multiblock_engine

Overview:
- Parametrised successor to the single-block SHA-256 engine.
- Hashes pre-padded messages of any number of 512-bit blocks, with chaining across blocks.
- Supports SHA-256 and SHA-224 modes, selected per message.
- Executes 1, 2 or 4 compression rounds per clock, using a rolling 16-word message schedule.
- Sits between the xy1en1om word FIFO (32-bit valid/ready stream) and the register bank that reads the hash.

Parameters:
- ROUNDS_PER_CLK, 1: compression rounds per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- BLKCNT_W, 16: width of the processed-block counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- init_i  in  1  start a new message; loads the IV; sampled every cycle
- mode_224_i  in  1  sampled with init_i: 1 = SHA-224, 0 = SHA-256
- dat_valid_i  in  1  word valid
- dat_ready_o  out  1  engine accepts a word
- dat_i  in  32  message word, big-endian, padding already applied
- dat_last_i  in  1  marks the 16th word of the final block
- busy_o  out  1  high in ROUND and FINAL
- hash_valid_o  out  1  final digest available
- hash_o  out  256  digest, H0 in bits [255:224]
- block_cnt_o  out  BLKCNT_W  blocks compressed since the last init
- proto_err_o  out  1  sticky: dat_last_i was seen on a non-16th word

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE.
  - dat_ready_o, busy_o, hash_valid_o, proto_err_o = 0.
  - hash_o = 0, block_cnt_o = 0, word counter = 0.
- A beat is a cycle with dat_valid_i & dat_ready_o. dat_ready_o is registered and is 1 only in LOAD.
- IDLE:
  - init_i = 1 → H0..H7 load the IV for mode_224_i. The SHA-224 IV is c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - Same edge: mode latched, block_cnt_o = 0, hash_valid_o = 0, proto_err_o = 0; next state LOAD.
- LOAD:
  - Each beat writes W[cnt] = dat_i, then cnt++.
  - dat_last_i on beats 0..14 sets proto_err_o and is otherwise ignored.
  - On beat 15: last_blk latched from dat_last_i; a..h ← H0..H7; cnt = 0; next state ROUND.
- ROUND:
  - Each cycle performs ROUNDS_PER_CLK SHA-2 rounds, t = cnt..cnt+R-1.
  - The schedule is a 16-entry shift window. For t ≥ 16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], all sums mod 2^32.
  - After 64/R cycles → FINAL.
- FINAL (1 cycle):
  - Hi ← Hi + {a..h}i mod 2^32; block_cnt_o++ (wraps at 2^BLKCNT_W).
  - last_blk = 1 → next IDLE; hash_valid_o = 1 from the following cycle.
  - last_blk = 0 → next LOAD.
- Digest output:
  - SHA-256: hash_o = {H0..H7}.
  - SHA-224: hash_o = {H0..H6, 32'h0}.
  - hash_o is updated only when hash_valid_o rises, and holds with hash_valid_o = 1 until the next init_i.
- Latency: 16th beat at edge T → hash_valid_o high at T + 64/R + 2. For R = 1 this is 66 cycles.
- Throughput: one block per 16 + 64/R + 1 cycles when the stream never stalls.
- dat_valid_i low in LOAD stalls the engine; the partial block is held indefinitely.
- init_i in LOAD, ROUND or FINAL aborts the current message.
  - Same actions as init in IDLE; next state LOAD, cnt = 0.
  - The pending FINAL update is discarded.
  - init_i has priority over a simultaneous beat; that word is dropped.
- init_i while hash_valid_o = 1 clears it on the same edge.
- Reset mid-operation returns every output to its reset value immediately, with no clock required.

Test Plan:
- "abc", SHA-256, R=1, one padded block → hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. Check hash_valid_o exactly 66 cycles after the 16th beat, and block_cnt_o = 1.
- Empty string, SHA-256, R=4 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Check latency of 18 cycles.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", two blocks, random dat_valid_i gaps, R=2 → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. block_cnt_o = 2.
- "abc", SHA-224 → hash_o = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- init_i asserted in ROUND mid-block, then the "abc" SHA-256 block is sent → correct "abc" digest, block_cnt_o = 1, no stale hash_valid_o pulse.
- dat_last_i on word 5 of a block → proto_err_o = 1 and stays high until the next init_i. Assert rst mid-ROUND → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sha2_multiblock_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_multiblock_engine
//  Description : SHA-256 / SHA-224 hash engine for pre-padded messages of
//                any number of 512-bit blocks. It chains H across blocks and
//                runs 1, 2 or 4 compression rounds per clock over a rolling
//                16-word message schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha2_multiblock_engine #(
    parameter int ROUNDS_PER_CLK = 1,
    parameter int BLKCNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_i,
    input  logic                mode_224_i,
    input  logic                dat_valid_i,
    output logic                dat_ready_o,
    input  logic [31:0]         dat_i,
    input  logic                dat_last_i,
    output logic                busy_o,
    output logic                hash_valid_o,
    output logic [255:0]        hash_o,
    output logic [BLKCNT_W-1:0] block_cnt_o,
    output logic                proto_err_o
);

    generate
        if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4) begin : g_bad_rounds
            $error("sha2_multiblock_engine: ROUNDS_PER_CLK must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [5:0] c_R_STEP = 6'(ROUNDS_PER_CLK);
    localparam logic [5:0] c_R_LAST = 6'(64 - ROUNDS_PER_CLK);

    localparam logic [255:0] c_IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_ssig0(input logic [31:0] x);
        return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_ssig1(input logic [31:0] x);
        return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round; st packs a..h with a in the top word, kw = K[t] + W[t].
    function automatic logic [255:0] f_round(input logic [255:0] st, input logic [31:0] kw);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (f_rotr(e, 6) ^ f_rotr(e, 11) ^ f_rotr(e, 25)) + ((e & f) ^ (~e & g)) + kw;
        t2 = (f_rotr(a, 2) ^ f_rotr(a, 13) ^ f_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Window holds W[t..t+15] with W[t] in the top word; drop W[t], append W[t+16].
    function automatic logic [511:0] f_sched(input logic [511:0] win);
        logic [31:0] nw;
        nw = f_ssig1(win[63:32]) + win[223:192] + f_ssig0(win[479:448]) + win[511:480];
        return {win[479:0], nw};
    endfunction

    function automatic logic [255:0] f_add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] s;
        for (int i = 0; i < 8; i++) begin
            s[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        end
        return s;
    endfunction

    state_t              r_state;
    logic [5:0]          r_cnt;
    logic [511:0]        r_win;
    logic [255:0]        r_v;
    logic [255:0]        r_hs;
    logic                r_mode;
    logic                r_last_blk;
    logic                r_pend;
    logic                r_ready;
    logic                r_busy;
    logic                r_hash_valid;
    logic [255:0]        r_hash;
    logic [BLKCNT_W-1:0] r_blk_cnt;
    logic                r_proto_err;

    logic [255:0]        w_st_nxt;
    logic [511:0]        w_win_nxt;
    logic [255:0]        w_hsum;
    logic [255:0]        w_digest;

    // Unrolled datapath: ROUNDS_PER_CLK chained rounds plus schedule shifts.
    always_comb begin
        w_st_nxt  = r_v;
        w_win_nxt = r_win;
        for (int j = 0; j < ROUNDS_PER_CLK; j++) begin
            w_st_nxt  = f_round(w_st_nxt, c_K[r_cnt + 6'(j)] + w_win_nxt[511:480]);
            w_win_nxt = f_sched(w_win_nxt);
        end
    end

    assign w_hsum   = f_add8(r_hs, r_v);
    assign w_digest = r_mode ? {r_hs[255:32], 32'h0} : r_hs;

    // Control FSM with registered handshake/status outputs and chaining value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            r_win        <= '0;
            r_v          <= '0;
            r_hs         <= '0;
            r_mode       <= 1'b0;
            r_last_blk   <= 1'b0;
            r_pend       <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_hash_valid <= 1'b0;
            r_hash       <= '0;
            r_blk_cnt    <= '0;
            r_proto_err  <= 1'b0;
        end else if (init_i) begin
            // New message (or abort): any in-flight block and pending digest are dropped.
            r_hs         <= mode_224_i ? c_IV224 : c_IV256;
            r_mode       <= mode_224_i;
            r_blk_cnt    <= '0;
            r_hash_valid <= 1'b0;
            r_proto_err  <= 1'b0;
            r_pend       <= 1'b0;
            r_cnt        <= 6'd0;
            r_state      <= S_LOAD;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Digest becomes visible one cycle after the last FINAL update.
                    if (r_pend) begin
                        r_pend       <= 1'b0;
                        r_hash_valid <= 1'b1;
                        r_hash       <= w_digest;
                    end
                end
                S_LOAD: begin
                    if (dat_valid_i && r_ready) begin
                        r_win <= {r_win[479:0], dat_i};
                        if (r_cnt == 6'd15) begin
                            r_last_blk <= dat_last_i;
                            r_v        <= r_hs;
                            r_cnt      <= 6'd0;
                            r_state    <= S_ROUND;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                            if (dat_last_i) begin
                                r_proto_err <= 1'b1;
                            end
                        end
                    end
                end
                S_ROUND: begin
                    r_v   <= w_st_nxt;
                    r_win <= w_win_nxt;
                    if (r_cnt == c_R_LAST) begin
                        r_cnt   <= 6'd0;
                        r_state <= S_FINAL;
                    end else begin
                        r_cnt <= r_cnt + c_R_STEP;
                    end
                end
                default: begin
                    r_hs      <= w_hsum;
                    r_blk_cnt <= r_blk_cnt + BLKCNT_W'(1);
                    r_busy    <= 1'b0;
                    if (r_last_blk) begin
                        r_state <= S_IDLE;
                        r_pend  <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign dat_ready_o  = r_ready;
    assign busy_o       = r_busy;
    assign hash_valid_o = r_hash_valid;
    assign hash_o       = r_hash;
    assign block_cnt_o  = r_blk_cnt;
    assign proto_err_o  = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_sha2_multiblock_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_multiblock_engine
//  Description : Self-checking bench for sha2_multiblock_engine. Three
//                instances (1, 2 and 4 rounds per clock) are driven
//                independently and compared against a message-level SHA-2
//                model plus literal reference digests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_multiblock_engine;

    localparam logic [255:0] c_IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] c_ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] c_EMPTY256 =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] c_56B256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] c_ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    localparam logic [31:0] c_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tb_init  [3];
    logic         tb_mode  [3];
    logic         tb_valid [3];
    logic [31:0]  tb_dat   [3];
    logic         tb_last  [3];
    logic         tb_ready [3];
    logic         tb_busy  [3];
    logic         tb_hv    [3];
    logic [255:0] tb_hash  [3];
    logic [15:0]  tb_bcnt  [3];
    logic         tb_perr  [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    bit           mdl_done [3];
    bit           mdl_perr [3];
    logic [255:0] mdl_hash [3];
    int           mdl_cnt  [3];
    logic [31:0]  msg [$];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            sha2_multiblock_engine #(
                .ROUNDS_PER_CLK(1 << g),
                .BLKCNT_W      (16)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .init_i      (tb_init[g]),
                .mode_224_i  (tb_mode[g]),
                .dat_valid_i (tb_valid[g]),
                .dat_ready_o (tb_ready[g]),
                .dat_i       (tb_dat[g]),
                .dat_last_i  (tb_last[g]),
                .busy_o      (tb_busy[g]),
                .hash_valid_o(tb_hv[g]),
                .hash_o      (tb_hash[g]),
                .block_cnt_o (tb_bcnt[g]),
                .proto_err_o (tb_perr[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- reference SHA-2 model (full 64-word expansion) --------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] hout;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_K[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    // ---------------- per-cycle compare against the model -------------------
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            for (int k = 0; k < 3; k++) begin
                chk("proto_err_track", 256'(tb_perr[k]), 256'(mdl_perr[k]));
                if (tb_hv[k]) begin
                    chk("valid_allowed", 256'(mdl_done[k]), 256'd1);
                    chk("digest_track", tb_hash[k], mdl_hash[k]);
                    chk("blkcnt_track", 256'(tb_bcnt[k]), 256'(mdl_cnt[k]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int k, input logic m224);
        tb_init[k] = 1'b1;
        tb_mode[k] = m224;
        tick();
        tb_init[k] = 1'b0;
        tb_mode[k] = 1'b0;
        mdl_done[k] = 1'b0;
        mdl_perr[k] = 1'b0;
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input logic last,
                             input bit flag_err, input int gap);
        bit took;
        int guard;
        for (int i = 0; i < gap; i++) tick();
        tb_valid[k] = 1'b1;
        tb_dat[k]   = w;
        tb_last[k]  = last;
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 400) begin
            @(negedge clk);
            took = tb_ready[k];
            tick();
            guard++;
        end
        tb_valid[k] = 1'b0;
        tb_last[k]  = 1'b0;
        chk("beat_accepted", 256'(took), 256'd1);
        if (took && flag_err) mdl_perr[k] = 1'b1;
    endtask

    task automatic run_msg(input int k, input logic m224, input int gapmax, input int errw,
                           output int lat, output logic [255:0] dig);
        logic [255:0] h;
        logic [31:0]  blk [16];
        int nblk, t0;
        bit seen, lastb;
        do_init(k, m224);
        chk("ready_after_init", 256'(tb_ready[k]), 256'd1);
        h    = m224 ? c_IV224 : c_IV256;
        nblk = msg.size() / 16;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 16; i++) begin
                blk[i] = msg[b*16 + i];
                lastb  = (b == nblk - 1);
                send_word(k, blk[i], lastb && (i == 15 || i == errw),
                          lastb && i == errw && i != 15, int'($urandom_range(0, gapmax)));
            end
            h = sha_blk(h, blk);
        end
        t0  = cyc;
        dig = m224 ? {h[255:32], 32'h0} : h;
        mdl_hash[k] = dig;
        mdl_cnt[k]  = nblk;
        mdl_done[k] = 1'b1;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (tb_hv[k]) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        chk("valid_seen", 256'(seen), 256'd1);
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(32'h61626380);
        for (int i = 0; i < 14; i++) msg.push_back(32'h0);
        msg.push_back(32'h00000018);
    endtask

    // ---------------- directed test sequence ----------------------------------
    initial begin
        int lat;
        logic [255:0] dig;
        logic [31:0] s56 [14];
        for (int k = 0; k < 3; k++) begin
            tb_init[k] = 1'b0; tb_mode[k] = 1'b0; tb_valid[k] = 1'b0;
            tb_dat[k]  = 32'h0; tb_last[k] = 1'b0;
            mdl_done[k] = 1'b0; mdl_perr[k] = 1'b0; mdl_hash[k] = '0; mdl_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("reset_ready", 256'(tb_ready[k]), 256'd0);
            chk("reset_busy",  256'(tb_busy[k]),  256'd0);
            chk("reset_valid", 256'(tb_hv[k]),    256'd0);
            chk("reset_hash",  tb_hash[k],        256'd0);
            chk("reset_bcnt",  256'(tb_bcnt[k]),  256'd0);
            chk("reset_perr",  256'(tb_perr[k]),  256'd0);
        end
        cmp_en = 1'b1;

        // "abc" SHA-256, 1 round/clk
        load_abc();
        run_msg(0, 1'b0, 0, -1, lat, dig);
        chk("model_abc256", dig, c_ABC256);
        chk("dut_abc256", tb_hash[0], c_ABC256);
        chk("lat_r1", 256'(lat), 256'd66);
        chk("bcnt_abc256", 256'(tb_bcnt[0]), 256'd1);

        // empty string SHA-256, 4 rounds/clk
        msg.delete();
        msg.push_back(32'h80000000);
        for (int i = 0; i < 15; i++) msg.push_back(32'h0);
        run_msg(2, 1'b0, 0, -1, lat, dig);
        chk("model_empty", dig, c_EMPTY256);
        chk("dut_empty", tb_hash[2], c_EMPTY256);
        chk("lat_r4", 256'(lat), 256'd18);

        // 56-byte two-block message, 2 rounds/clk, random valid gaps
        s56 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        msg.delete();
        for (int i = 0; i < 14; i++) msg.push_back(s56[i]);
        msg.push_back(32'h80000000);
        for (int i = 0; i < 16; i++) msg.push_back(32'h0);
        msg.push_back(32'h000001c0);
        run_msg(1, 1'b0, 3, -1, lat, dig);
        chk("model_56b", dig, c_56B256);
        chk("dut_56b", tb_hash[1], c_56B256);
        chk("bcnt_56b", 256'(tb_bcnt[1]), 256'd2);

        // "abc" SHA-224, 1 round/clk
        load_abc();
        run_msg(0, 1'b1, 0, -1, lat, dig);
        chk("model_abc224", dig, c_ABC224);
        chk("dut_abc224", tb_hash[0], c_ABC224);

        // abort mid-ROUND on the 2 rounds/clk engine, then hash "abc"
        do_init(1, 1'b0);
        for (int i = 0; i < 16; i++) send_word(1, (i == 0) ? 32'h80000000 : 32'h0, 1'b0, 1'b0, 0);
        repeat (5) tick();
        chk("busy_in_round", 256'(tb_busy[1]), 256'd1);
        load_abc();
        run_msg(1, 1'b0, 0, -1, lat, dig);
        chk("dut_abort_abc", tb_hash[1], c_ABC256);
        chk("bcnt_abort", 256'(tb_bcnt[1]), 256'd1);
        chk("lat_r2", 256'(lat), 256'd34);

        // dat_last_i on word 5 sets a sticky error that only init clears
        load_abc();
        run_msg(2, 1'b0, 0, 5, lat, dig);
        chk("perr_set", 256'(tb_perr[2]), 256'd1);
        chk("dut_perr_abc", tb_hash[2], c_ABC256);
        do_init(2, 1'b0);
        chk("perr_cleared", 256'(tb_perr[2]), 256'd0);
        for (int i = 0; i < 6; i++) send_word(2, 32'h0, i == 3, i == 3, 0);
        chk("perr_partial", 256'(tb_perr[2]), 256'd1);

        // asynchronous reset in the middle of ROUND
        load_abc();
        do_init(0, 1'b0);
        for (int i = 0; i < 16; i++) send_word(0, msg[i], i == 15, 1'b0, 0);
        repeat (5) tick();
        chk("busy_pre_reset", 256'(tb_busy[0]), 256'd1);
        chk("valid_pre_reset", 256'(tb_hv[1]), 256'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_ready", 256'(tb_ready[k]), 256'd0);
            chk("async_busy",  256'(tb_busy[k]),  256'd0);
            chk("async_valid", 256'(tb_hv[k]),    256'd0);
            chk("async_hash",  tb_hash[k],        256'd0);
            chk("async_bcnt",  256'(tb_bcnt[k]),  256'd0);
            chk("async_perr",  256'(tb_perr[k]),  256'd0);
            mdl_done[k] = 1'b0;
            mdl_perr[k] = 1'b0;
        end
        tick();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 256'(tb_ready[0]), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
